sent_cfg_ctrl: RTL and testbench

SENT_CFG_CTRL -- requirements
Module: sent_cfg_ctrl

---
 rtl/sent_cfg_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sent_cfg_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sent_cfg_ctrl.sv
// sent_cfg_ctrl
//   Parses SENT parameter packets arriving on a UDP payload stream and hands
//   validated configurations to one of SENT_NUM channels via a valid/ready
//   handshake. A single pending-config register is shared by all channels.
//   A config that arrives while an older one is still pending replaces it.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   rx_axis_udp_*        32-bit payload stream (no backpressure)
//   cfg_valid[SENT_NUM]  one-hot, pending config targets this channel
//   cfg_ready[SENT_NUM]  channel can take a config this cycle
//   cfg_*                fields of the pending config (shared)
//   err_len/err_param/cfg_ovf  one-cycle error/overwrite pulses
module sent_cfg_ctrl #(
  parameter int          SENT_NUM      = 5,
  parameter logic [15:0] ID_SENT_PARAM = 16'd2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         rx_axis_udp_tdata,
  input  logic                rx_axis_udp_tvalid,
  input  logic                rx_axis_udp_tlast,
  output logic [SENT_NUM-1:0] cfg_valid,
  input  logic [SENT_NUM-1:0] cfg_ready,
  output logic [7:0]          cfg_ctick_len,
  output logic [7:0]          cfg_ltick_len,
  output logic [1:0]          cfg_pause_mode,
  output logic [15:0]         cfg_pause_len,
  output logic                cfg_crc_mode,
  output logic                err_len,
  output logic                err_param,
  output logic                cfg_ovf
);

  typedef enum logic [1:0] {S_HDR, S_W1, S_W2, S_DROP} state_t;

  state_t state_q, state_d;

  // Fields captured from W0/W1 while the packet is still in flight
  logic [7:0] w_ch_q, w_ctick_q, w_ltick_q, w_plhi_q;
  logic [1:0] w_pmode_q;

  // Pending config register
  logic [SENT_NUM-1:0] cfg_valid_q, cfg_valid_d;
  logic [7:0]          ctick_q, ltick_q;
  logic [1:0]          pmode_q;
  logic [15:0]         plen_q;
  logic                crc_q;

  logic err_len_q, err_param_q, cfg_ovf_q;

  logic        id_hit, hdr_take, w1_take, w2_done, len_err;
  logic        cfg_ok, load, xfer;
  logic [15:0] plen_new;

  assign id_hit   = (rx_axis_udp_tdata[31:16] == ID_SENT_PARAM);
  assign hdr_take = rx_axis_udp_tvalid && (state_q == S_HDR) && id_hit && !rx_axis_udp_tlast;
  assign w1_take  = rx_axis_udp_tvalid && (state_q == S_W1);

  // Parser next state
  always_comb begin
    state_d = state_q;
    len_err = 1'b0;
    w2_done = 1'b0;
    if (rx_axis_udp_tvalid) begin
      unique case (state_q)
        S_HDR: begin
          // single-word packet: only our own ID counts as a length error
          if (rx_axis_udp_tlast) len_err = id_hit;
          else                   state_d = id_hit ? S_W1 : S_DROP;
        end
        S_W1: begin
          if (rx_axis_udp_tlast) begin
            len_err = 1'b1;
            state_d = S_HDR;
          end else begin
            state_d = S_W2;
          end
        end
        S_W2: begin
          if (rx_axis_udp_tlast) begin
            w2_done = 1'b1;
            state_d = S_HDR;
          end else begin
            len_err = 1'b1;
            state_d = S_DROP;
          end
        end
        S_DROP: begin
          if (rx_axis_udp_tlast) state_d = S_HDR;
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  // Validation runs on the W2 word itself so the config lands one cycle later
  assign plen_new = {w_plhi_q, rx_axis_udp_tdata[31:24]};
  assign cfg_ok   = (int'(w_ch_q) < SENT_NUM) &&
                    (w_ctick_q >= 8'd3) && (w_ctick_q <= 8'd90) &&
                    (w_ltick_q >= 8'd4) &&
                    (w_pmode_q <= 2'd2) &&
                    ((w_pmode_q == 2'd0) || ((plen_new >= 16'd12) && (plen_new <= 16'd768)));
  assign load     = w2_done && cfg_ok;
  assign xfer     = |(cfg_valid_q & cfg_ready);

  always_comb begin
    cfg_valid_d = cfg_valid_q;
    if (load) begin
      for (int i = 0; i < SENT_NUM; i++) cfg_valid_d[i] = (w_ch_q == 8'(i));
    end else if (xfer) begin
      cfg_valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR;
      w_ch_q      <= '0;
      w_ctick_q   <= '0;
      w_ltick_q   <= '0;
      w_plhi_q    <= '0;
      w_pmode_q   <= '0;
      cfg_valid_q <= '0;
      ctick_q     <= '0;
      ltick_q     <= '0;
      pmode_q     <= '0;
      plen_q      <= '0;
      crc_q       <= 1'b0;
      err_len_q   <= 1'b0;
      err_param_q <= 1'b0;
      cfg_ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hdr_take) w_ch_q <= rx_axis_udp_tdata[15:8];
      if (w1_take) begin
        w_ctick_q <= rx_axis_udp_tdata[31:24];
        w_ltick_q <= rx_axis_udp_tdata[23:16];
        w_pmode_q <= rx_axis_udp_tdata[9:8];
        w_plhi_q  <= rx_axis_udp_tdata[7:0];
      end
      cfg_valid_q <= cfg_valid_d;
      if (load) begin
        ctick_q <= w_ctick_q;
        ltick_q <= w_ltick_q;
        pmode_q <= w_pmode_q;
        plen_q  <= plen_new;
        crc_q   <= rx_axis_udp_tdata[16];
      end
      err_len_q   <= len_err;
      err_param_q <= w2_done && !cfg_ok;
      // overwrite only if the old config is not leaving this same cycle
      cfg_ovf_q   <= load && (|cfg_valid_q) && !xfer;
    end
  end

  assign cfg_valid      = cfg_valid_q;
  assign cfg_ctick_len  = ctick_q;
  assign cfg_ltick_len  = ltick_q;
  assign cfg_pause_mode = pmode_q;
  assign cfg_pause_len  = plen_q;
  assign cfg_crc_mode   = crc_q;
  assign err_len        = err_len_q;
  assign err_param      = err_param_q;
  assign cfg_ovf        = cfg_ovf_q;

endmodule

// File: tb/tb_sent_cfg_ctrl.sv
// Bench for sent_cfg_ctrl: directed scenarios plus randomized packets, with a
// packet-level reference model checked every cycle.
module tb_sent_cfg_ctrl;
  localparam int          N  = 5;
  localparam logic [15:0] ID = 16'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   tdata = '0;
  logic          tvalid = 1'b0, tlast = 1'b0;
  logic [N-1:0]  cfg_valid, cfg_ready = '0;
  logic [7:0]    cfg_ctick_len, cfg_ltick_len;
  logic [1:0]    cfg_pause_mode;
  logic [15:0]   cfg_pause_len;
  logic          cfg_crc_mode, err_len, err_param, cfg_ovf;

  int checks = 0, errors = 0;
  logic [N-1:0] rdy = '0;   // ready value applied with the next driven cycle

  sent_cfg_ctrl #(.SENT_NUM(N), .ID_SENT_PARAM(ID)) dut (
    .clk(clk), .rst(rst),
    .rx_axis_udp_tdata(tdata), .rx_axis_udp_tvalid(tvalid), .rx_axis_udp_tlast(tlast),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ctick_len(cfg_ctick_len), .cfg_ltick_len(cfg_ltick_len),
    .cfg_pause_mode(cfg_pause_mode), .cfg_pause_len(cfg_pause_len),
    .cfg_crc_mode(cfg_crc_mode),
    .err_len(err_len), .err_param(err_param), .cfg_ovf(cfg_ovf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (packet position based) ----------------
  int          pos = 0;
  bit          match = 0;
  int          m_ch, m_ct, m_lt, m_pm, m_pl, m_crc;
  bit          e_vld = 0;
  int          e_ch = 0, e_ct = 0, e_lt = 0, e_pm = 0, e_pl = 0, e_crc = 0;
  bit          e_len = 0, e_par = 0, e_ovf = 0;

  function automatic bit cfg_legal(int ch, int ct, int lt, int pm, int pl);
    return (ch < N) && (ct >= 3) && (ct <= 90) && (lt >= 4) && (pm <= 2) &&
           (pm == 0 || (pl >= 12 && pl <= 768));
  endfunction

  always @(posedge clk) begin
    bit ld, xf;
    logic [N-1:0] ev;
    ld = 0; e_len = 0; e_par = 0; e_ovf = 0;
    if (rst) begin
      pos = 0; match = 0; e_vld = 0;
      e_ch = 0; e_ct = 0; e_lt = 0; e_pm = 0; e_pl = 0; e_crc = 0;
    end else begin
      if (tvalid) begin
        if (pos == 0) begin match = (tdata[31:16] == ID); m_ch = int'(tdata[15:8]); end
        if (pos == 1) begin
          m_ct = int'(tdata[31:24]); m_lt = int'(tdata[23:16]);
          m_pm = int'(tdata[9:8]);   m_pl = int'(tdata[7:0]) * 256;
        end
        if (pos == 2) begin m_pl = m_pl + int'(tdata[31:24]); m_crc = int'(tdata[16]); end
        if (match && ((pos <= 1 && tlast) || (pos == 2 && !tlast))) e_len = 1;
        if (match && pos == 2 && tlast) begin
          if (cfg_legal(m_ch, m_ct, m_lt, m_pm, m_pl)) ld = 1; else e_par = 1;
        end
        pos = tlast ? 0 : pos + 1;
      end
      xf = e_vld && cfg_ready[e_ch];
      if (ld) begin
        e_ovf = e_vld && !xf;
        e_vld = 1; e_ch = m_ch; e_ct = m_ct; e_lt = m_lt; e_pm = m_pm; e_pl = m_pl; e_crc = m_crc;
      end else if (xf) begin
        e_vld = 0;
      end
    end
    #1;
    ev = '0;
    if (e_vld) ev[e_ch] = 1'b1;
    checks++;
    if (cfg_valid !== ev || cfg_ctick_len !== 8'(e_ct) || cfg_ltick_len !== 8'(e_lt) ||
        cfg_pause_mode !== 2'(e_pm) || cfg_pause_len !== 16'(e_pl) || cfg_crc_mode !== 1'(e_crc) ||
        err_len !== e_len || err_param !== e_par || cfg_ovf !== e_ovf) begin
      errors++;
      if (errors < 20)
        $display("FAIL model t=%0t got v=%b ct=%0d lt=%0d pm=%0d pl=%0d crc=%b el=%b ep=%b ov=%b exp v=%b ct=%0d lt=%0d pm=%0d pl=%0d crc=%0d el=%b ep=%b ov=%b",
                 $time, cfg_valid, cfg_ctick_len, cfg_ltick_len, cfg_pause_mode, cfg_pause_len,
                 cfg_crc_mode, err_len, err_param, cfg_ovf, ev, e_ct, e_lt, e_pm, e_pl, e_crc,
                 e_len, e_par, e_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic word(input logic [31:0] d, input logic last);
    @(negedge clk);
    tdata = d; tvalid = 1'b1; tlast = last; cfg_ready = rdy;
  endtask

  task automatic idle();
    @(negedge clk);
    tdata = $urandom; tvalid = 1'b0; tlast = 1'b0; cfg_ready = rdy;
  endtask

  function automatic logic [31:0] w0(input logic [15:0] id, input logic [7:0] ch);
    return {id, ch, 8'h00};
  endfunction
  function automatic logic [31:0] w1(input logic [7:0] ct, input logic [7:0] lt,
                                     input logic [1:0] pm, input logic [15:0] pl);
    return {ct, lt, 6'b0, pm, pl[15:8]};
  endfunction
  function automatic logic [31:0] w2(input logic [15:0] pl, input logic crc);
    return {pl[7:0], 7'b0, crc, 16'h0000};
  endfunction

  task automatic pkt(input logic [7:0] ch, input logic [7:0] ct, input logic [7:0] lt,
                     input logic [1:0] pm, input logic [15:0] pl, input logic crc);
    word(w0(ID, ch), 1'b0);
    word(w1(ct, lt, pm, pl), 1'b0);
    word(w2(pl, crc), 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; rdy = '0;
    repeat (3) idle();
    checks++;
    if (cfg_valid !== '0 || err_len !== 0 || err_param !== 0 || cfg_ovf !== 0 ||
        cfg_ctick_len !== 0 || cfg_pause_len !== 0) begin
      errors++; $display("FAIL reset_outputs got v=%b ct=%0d pl=%0d exp all zero", cfg_valid, cfg_ctick_len, cfg_pause_len);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_basic();
    rdy = 5'h1F;
    pkt(8'd0, 8'd3, 8'd4, 2'd0, 16'd10, 1'b0);
    idle();
    checks++;
    if (cfg_valid !== 5'b00001 || cfg_ctick_len !== 8'd3 || cfg_ltick_len !== 8'd4 ||
        cfg_pause_mode !== 2'd0 || cfg_pause_len !== 16'd10 || cfg_crc_mode !== 1'b0) begin
      errors++; $display("FAIL basic_load got v=%b ct=%0d lt=%0d pl=%0d exp 00001 3 4 10", cfg_valid, cfg_ctick_len, cfg_ltick_len, cfg_pause_len);
    end
    idle();
    checks++;
    if (cfg_valid !== 5'b0 || cfg_ctick_len !== 8'd3) begin
      errors++; $display("FAIL basic_clear got v=%b ct=%0d exp 00000 3", cfg_valid, cfg_ctick_len);
    end
  endtask

  task automatic test_param_err();
    rdy = 5'h1F;
    pkt(8'd1, 8'd91, 8'd4, 2'd0, 16'd0, 1'b0);
    idle();
    checks++;
    if (err_param !== 1'b1 || cfg_valid !== '0) begin
      errors++; $display("FAIL param_ctick91 got ep=%b v=%b exp 1 00000", err_param, cfg_valid);
    end
    pkt(8'd1, 8'd10, 8'd4, 2'd1, 16'd11, 1'b0);
    idle();
    checks++;
    if (err_param !== 1'b1 || cfg_valid !== '0) begin
      errors++; $display("FAIL param_pause11 got ep=%b v=%b exp 1 00000", err_param, cfg_valid);
    end
    pkt(8'd5, 8'd10, 8'd4, 2'd0, 16'd0, 1'b0);
    idle();
    checks++;
    if (err_param !== 1'b1 || cfg_valid !== '0) begin
      errors++; $display("FAIL param_ch5 got ep=%b v=%b exp 1 00000", err_param, cfg_valid);
    end
    // upper boundaries that must be accepted
    pkt(8'd4, 8'd90, 8'd255, 2'd2, 16'd768, 1'b1);
    idle();
    checks++;
    if (err_param !== 1'b0 || cfg_valid !== 5'b10000 || cfg_pause_len !== 16'd768 || cfg_crc_mode !== 1'b1) begin
      errors++; $display("FAIL param_bound got ep=%b v=%b pl=%0d crc=%b exp 0 10000 768 1", err_param, cfg_valid, cfg_pause_len, cfg_crc_mode);
    end
    idle();
  endtask

  task automatic test_foreign_id();
    rdy = 5'h1F;
    word(w0(16'd3, 8'd0), 1'b0);
    word(w1(8'd10, 8'd10, 2'd0, 16'd0), 1'b0);
    word(w2(16'd0, 1'b0), 1'b1);
    idle();
    checks++;
    if (cfg_valid !== '0 || err_len !== 0 || err_param !== 0) begin
      errors++; $display("FAIL foreign_id got v=%b el=%b ep=%b exp 0 0 0", cfg_valid, err_len, err_param);
    end
    pkt(8'd2, 8'd20, 8'd5, 2'd1, 16'd12, 1'b0);
    idle();
    checks++;
    if (cfg_valid !== 5'b00100 || cfg_pause_len !== 16'd12) begin
      errors++; $display("FAIL after_foreign got v=%b pl=%0d exp 00100 12", cfg_valid, cfg_pause_len);
    end
    idle();
  endtask

  task automatic test_len_err();
    rdy = 5'h1F;
    word(w0(ID, 8'd1), 1'b0);
    word(w1(8'd10, 8'd10, 2'd0, 16'd0), 1'b1);
    idle();
    checks++;
    if (err_len !== 1'b1) begin
      errors++; $display("FAIL len_short got el=%b exp 1", err_len);
    end
    word(w0(ID, 8'd1), 1'b0);
    word(w1(8'd10, 8'd10, 2'd0, 16'd0), 1'b0);
    word(w2(16'd0, 1'b0), 1'b0);
    word(w0(ID, 8'd1), 1'b1);          // 4th word, must be dropped silently
    checks++;
    if (err_len !== 1'b1) begin
      errors++; $display("FAIL len_long got el=%b exp 1", err_len);
    end
    idle();
    checks++;
    if (err_len !== 1'b0 || cfg_valid !== '0) begin
      errors++; $display("FAIL len_drop got el=%b v=%b exp 0 00000", err_len, cfg_valid);
    end
  endtask

  task automatic test_overwrite();
    rdy = '0;
    pkt(8'd1, 8'd10, 8'd4, 2'd0, 16'd0, 1'b0);
    pkt(8'd2, 8'd50, 8'd4, 2'd0, 16'd0, 1'b0);
    idle();
    checks++;
    if (cfg_ovf !== 1'b1 || cfg_valid !== 5'b00100 || cfg_ctick_len !== 8'd50) begin
      errors++; $display("FAIL ovf got ov=%b v=%b ct=%0d exp 1 00100 50", cfg_ovf, cfg_valid, cfg_ctick_len);
    end
    idle();
    checks++;
    if (cfg_valid !== 5'b00100) begin
      errors++; $display("FAIL ovf_hold got v=%b exp 00100", cfg_valid);
    end
    rdy = 5'b00100;
    idle();
    idle();
    checks++;
    if (cfg_valid !== '0) begin
      errors++; $display("FAIL ovf_xfer got v=%b exp 00000", cfg_valid);
    end
    // load while transfer happens in the same cycle
    rdy = '0;
    pkt(8'd1, 8'd11, 8'd4, 2'd0, 16'd0, 1'b0);
    word(w0(ID, 8'd3), 1'b0);
    word(w1(8'd33, 8'd4, 2'd0, 16'd0), 1'b0);
    rdy = 5'b00010;
    word(w2(16'd0, 1'b1), 1'b1);
    rdy = '0;
    idle();
    checks++;
    if (cfg_ovf !== 1'b0 || cfg_valid !== 5'b01000 || cfg_ctick_len !== 8'd33) begin
      errors++; $display("FAIL xfer_load got ov=%b v=%b ct=%0d exp 0 01000 33", cfg_ovf, cfg_valid, cfg_ctick_len);
    end
    rdy = 5'h1F;
    idle();
  endtask

  task automatic test_mid_reset();
    rdy = '0;
    pkt(8'd0, 8'd10, 8'd4, 2'd0, 16'd0, 1'b0);   // leave something pending
    word(w0(ID, 8'd1), 1'b0);
    word(w1(8'd10, 8'd4, 2'd0, 16'd0), 1'b0);
    @(negedge clk); tvalid = 1'b0; tlast = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if (cfg_valid !== '0 || cfg_ctick_len !== 0 || err_len !== 0 || err_param !== 0 || cfg_ovf !== 0) begin
      errors++; $display("FAIL midrst_clear got v=%b ct=%0d exp 0 0", cfg_valid, cfg_ctick_len);
    end
    word(w2(16'd0, 1'b0), 1'b1);
    idle();
    checks++;
    if (cfg_valid !== '0 || err_param !== 0) begin
      errors++; $display("FAIL midrst_w2 got v=%b ep=%b exp 00000 0", cfg_valid, err_param);
    end
    idle();
  endtask

  task automatic test_random();
    logic [7:0]  ct_t [7] = '{8'd2, 8'd3, 8'd4, 8'd50, 8'd90, 8'd91, 8'd200};
    logic [15:0] pl_t [6] = '{16'd11, 16'd12, 16'd300, 16'd768, 16'd769, 16'd0};
    for (int p = 0; p < 400; p++) begin
      int          len, r;
      logic [15:0] id, pl;
      logic [7:0]  ch, ct, lt;
      logic [1:0]  pm;
      if ($urandom_range(0, 59) == 0) begin
        @(negedge clk); rst = 1'b1; tvalid = 1'b0;
        @(negedge clk); rst = 1'b0;
      end
      r   = $urandom_range(0, 9);
      len = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 4 : (r == 3) ? 5 : 3;
      id  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : ID;
      ch  = 8'($urandom_range(0, 6));
      ct  = ($urandom_range(0, 1) == 0) ? ct_t[$urandom_range(0, 6)] : 8'($urandom_range(3, 90));
      lt  = 8'($urandom_range(2, 40));
      pm  = 2'($urandom);
      pl  = ($urandom_range(0, 1) == 0) ? pl_t[$urandom_range(0, 5)] : 16'($urandom_range(0, 1000));
      for (int w = 0; w < len; w++) begin
        logic [31:0] d;
        d = (w == 0) ? w0(id, ch) : (w == 1) ? w1(ct, lt, pm, pl) : (w == 2) ? w2(pl, $urandom_range(0, 1) == 1) : $urandom;
        rdy = N'($urandom) & N'($urandom);
        word(d, w == len - 1);
        if ($urandom_range(0, 4) == 0) idle();
      end
    end
    rdy = '1;
    repeat (3) idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_param_err();
    test_foreign_id();
    test_len_err();
    test_overwrite();
    test_mid_reset();
    test_random();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
